// File: rtl/dmem_pkg.sv
// Shared encodings for the wait-state data memory: access sizes, FSM states
// and the wait counter width.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering for byte/halfword/word accesses: byte enables,
// replicated store data, extended load data and the misalignment flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addrLo_i,
    input  logic        signedLd_i,
    input  logic [31:0] storeData_i,
    input  logic [31:0] readWord_i,
    output logic [3:0]  byteEn_o,
    output logic [31:0] storeWord_o,
    output logic [31:0] loadData_o,
    output logic        misalign_o
);

    logic [7:0]  readByte;
    logic [15:0] readHalf;

    assign readByte = readWord_i[{addrLo_i, 3'b000} +: 8];
    assign readHalf = addrLo_i[1] ? readWord_i[31:16] : readWord_i[15:0];

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byteEn_o    = 4'hF;
        storeWord_o = storeData_i;
        loadData_o  = readWord_i;
        misalign_o  = (addrLo_i != 2'b00);
        case (size_i)
            SZ_BYTE: begin
                byteEn_o    = 4'b0001 << addrLo_i;
                storeWord_o = {4{storeData_i[7:0]}};
                loadData_o  = {{24{signedLd_i & readByte[7]}}, readByte};
                misalign_o  = 1'b0;
            end
            SZ_HALF: begin
                byteEn_o    = addrLo_i[1] ? 4'b1100 : 4'b0011;
                storeWord_o = {2{storeData_i[15:0]}};
                loadData_o  = {{16{signedLd_i & readHalf[15]}}, readHalf};
                misalign_o  = addrLo_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_ws.sv
// MEM-stage data memory with sized accesses, error checking and WAIT_CYCLES wait states.
// Define DMEM_RESET_CLEAR_EN to clear the whole array on reset (otherwise RAM-inferable).
module data_memory_ws
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_r_en_i,
    input  logic              mem_w_en_i,
    input  logic [31:0]       address_i,
    input  logic [1:0]        size_i,
    input  logic              signed_ld_i,
    input  logic [DATA_W-1:0] dataIn_i,
    output logic [DATA_W-1:0] dataOut_o,
    output logic              ready_o,
    output logic              err_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic          request;
    logic          inRange;
    logic          misalign;
    logic          accessErr;
    logic          complete;
    logic          writeEn;
    logic [AW-1:0] wordIdx;
    logic [3:0]    byteEn;
    logic [31:0]   storeWord;
    logic [31:0]   loadData;
    logic [31:0]   readWord;

    assign request   = mem_r_en_i | mem_w_en_i;
    assign wordIdx   = address_i[AW+1:2];
    assign inRange   = (address_i[31:AW+2] == '0);
    assign readWord  = mem[wordIdx];
    assign accessErr = misalign | ~inRange;

    // An abandoned request must not see ready, so ready also requires the request.
    assign ready_o   = (WAIT_CYCLES == 0) ? 1'b1
                     : ((state_q == WAIT) && (cnt_q == '0) && request);
    assign complete  = ready_o & request & rst_n;
    assign err_o     = complete & accessErr;
    assign dataOut_o = (complete & mem_r_en_i & ~accessErr) ? loadData : '0;
    assign writeEn   = complete & mem_w_en_i & ~accessErr;

    dmem_lane_align u_align (
        .size_i      (size_i),
        .addrLo_i    (address_i[1:0]),
        .signedLd_i  (signed_ld_i),
        .storeData_i (dataIn_i),
        .readWord_i  (readWord),
        .byteEn_o    (byteEn),
        .storeWord_o (storeWord),
        .loadData_o  (loadData),
        .misalign_o  (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request && (WAIT_CYCLES > 0)) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
                    end
                end
                WAIT: begin
                    if (!request || (cnt_q == '0)) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (writeEn) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[wordIdx][8*b +: 8] <= storeWord[8*b +: 8];
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (writeEn) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[wordIdx][8*b +: 8] <= storeWord[8*b +: 8];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed self-checking bench for data_memory_ws with zero, three and two wait states;
// honours DMEM_RESET_CLEAR_EN when predicting contents after reset.
module tb_data_memory_ws;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=3, index 2: WAIT_CYCLES=2
    logic        rEn  [3];
    logic        wEn  [3];
    logic        sgn  [3];
    logic        rdy  [3];
    logic        er   [3];
    logic [1:0]  sz   [3];
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];

    int checks = 0;
    int errors = 0;

    data_memory_ws #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_r_en_i(rEn[0]), .mem_w_en_i(wEn[0]),
        .address_i(addr[0]), .size_i(sz[0]), .signed_ld_i(sgn[0]), .dataIn_i(din[0]),
        .dataOut_o(dout[0]), .ready_o(rdy[0]), .err_o(er[0])
    );

    data_memory_ws #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_r_en_i(rEn[1]), .mem_w_en_i(wEn[1]),
        .address_i(addr[1]), .size_i(sz[1]), .signed_ld_i(sgn[1]), .dataIn_i(din[1]),
        .dataOut_o(dout[1]), .ready_o(rdy[1]), .err_o(er[1])
    );

    data_memory_ws #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_r_en_i(rEn[2]), .mem_w_en_i(wEn[2]),
        .address_i(addr[2]), .size_i(sz[2]), .signed_ld_i(sgn[2]), .dataIn_i(din[2]),
        .dataOut_o(dout[2]), .ready_o(rdy[2]), .err_o(er[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int d, input logic r, input logic w,
                                 input logic [31:0] a, input logic [1:0] s,
                                 input logic sg, input logic [31:0] di);
        @(negedge clk);
        rEn[d]  = r;
        wEn[d]  = w;
        addr[d] = a;
        sz[d]   = s;
        sgn[d]  = sg;
        din[d]  = di;
        #1;
    endtask

    task automatic holdCycle();
        @(negedge clk);
        #1;
    endtask

    // Called in the first cycle of a held request; returns in the ready cycle.
    task automatic expectLatency(input int d, input int waits, input string tag);
        for (int i = 0; i < waits; i++) begin
            checkOutput({tag, "_notready"}, 32'(rdy[d]), 32'd0);
            checkOutput({tag, "_dout_idle"}, dout[d], 32'd0);
            holdCycle();
        end
        checkOutput({tag, "_ready"}, 32'(rdy[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] afterReset;

        for (int d = 0; d < 3; d++) begin
            rEn[d] = 1'b0; wEn[d] = 1'b0; addr[d] = '0;
            sz[d] = SZ_WORD; sgn[d] = 1'b0; din[d] = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_ready_w0", 32'(rdy[0]), 32'd1);
        checkOutput("rst_err_w0",   32'(er[0]),  32'd0);
        checkOutput("rst_dout_w0",  dout[0],     32'd0);
        checkOutput("rst_ready_w3", 32'(rdy[1]), 32'd0);
        checkOutput("rst_ready_w2", 32'(rdy[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero wait states: one access per cycle
        applyStimulus(0, 1'b0, 1'b1, 32'h10, SZ_WORD, 1'b0, 32'hDEADBEEF);
        checkOutput("w0_st_ready", 32'(rdy[0]), 32'd1);
        checkOutput("w0_st_err",   32'(er[0]),  32'd0);
        checkOutput("w0_st_dout",  dout[0],     32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0);
        checkOutput("w0_ld_ready", 32'(rdy[0]), 32'd1);
        checkOutput("w0_ld_word",  dout[0],     32'hDEADBEEF);

        applyStimulus(0, 1'b0, 1'b1, 32'h10, SZ_WORD, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 32'h13, SZ_BYTE, 1'b0, 32'h12345680);
        applyStimulus(0, 1'b1, 1'b0, 32'h13, SZ_BYTE, 1'b1, 32'h0);
        checkOutput("ld_byte_signed",   dout[0], 32'hFFFFFF80);
        applyStimulus(0, 1'b1, 1'b0, 32'h13, SZ_BYTE, 1'b0, 32'h0);
        checkOutput("ld_byte_unsigned", dout[0], 32'h00000080);
        applyStimulus(0, 1'b1, 1'b0, 32'h12, SZ_HALF, 1'b1, 32'h0);
        checkOutput("ld_half_signed",   dout[0], 32'hFFFF8000);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0);
        checkOutput("ld_word_after_byte", dout[0], 32'h80000000);

        applyStimulus(0, 1'b0, 1'b1, 32'h10, SZ_HALF, 1'b0, 32'hFFFF1234);
        applyStimulus(0, 1'b1, 1'b1, 32'h10, SZ_WORD, 1'b0, 32'h11223344);
        checkOutput("rw_pre_store",  dout[0], 32'h80001234);
        checkOutput("rw_err",        32'(er[0]), 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0);
        checkOutput("rw_post_store", dout[0], 32'h11223344);

        applyStimulus(0, 1'b0, 1'b1, 32'h11, SZ_HALF, 1'b0, 32'h0000AAAA);
        checkOutput("mis_half_err",  32'(er[0]), 32'd1);
        checkOutput("mis_half_dout", dout[0],    32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'h12, SZ_WORD, 1'b0, 32'h0);
        checkOutput("mis_word_err",  32'(er[0]), 32'd1);
        checkOutput("mis_word_dout", dout[0],    32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0);
        checkOutput("mis_unchanged", dout[0],    32'h11223344);

        applyStimulus(0, 1'b0, 1'b1, 32'h0, SZ_WORD, 1'b0, 32'h55AA55AA);
        applyStimulus(0, 1'b1, 1'b1, 32'h100, SZ_WORD, 1'b0, 32'hFFFFFFFF);
        checkOutput("oor_st_err",  32'(er[0]), 32'd1);
        checkOutput("oor_st_dout", dout[0],    32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'h102, SZ_WORD, 1'b0, 32'h0);
        checkOutput("oor_ld_err",  32'(er[0]), 32'd1);
        checkOutput("oor_ld_dout", dout[0],    32'd0);
        applyStimulus(0, 1'b0, 1'b1, 32'hFC, SZ_WORD, 1'b0, 32'hCAFEF00D);
        checkOutput("last_st_err", 32'(er[0]), 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'hFC, SZ_WORD, 1'b0, 32'h0);
        checkOutput("last_ld",     dout[0],    32'hCAFEF00D);
        applyStimulus(0, 1'b1, 1'b0, 32'h0, SZ_WORD, 1'b0, 32'h0);
        checkOutput("oor_no_alias", dout[0],   32'h55AA55AA);
        applyStimulus(0, 1'b1, 1'b0, 32'hFE, SZ_HALF, 1'b0, 32'h0);
        checkOutput("ld_half_unsigned", dout[0], 32'h0000CAFE);
        applyStimulus(0, 1'b1, 1'b0, 32'hFE, SZ_HALF, 1'b1, 32'h0);
        checkOutput("ld_half_hi_signed", dout[0], 32'hFFFFCAFE);
        applyStimulus(0, 1'b0, 1'b0, 32'hFC, SZ_WORD, 1'b0, 32'h0);
        checkOutput("w0_idle_dout", dout[0],    32'd0);
        checkOutput("w0_idle_err",  32'(er[0]), 32'd0);

        // Three wait states: four-cycle latency, back-to-back loads
        applyStimulus(1, 1'b0, 1'b1, 32'h40, SZ_WORD, 1'b0, 32'h0BADF00D);
        expectLatency(1, 3, "w3_st");
        checkOutput("w3_st_err", 32'(er[1]), 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 32'h40, SZ_WORD, 1'b0, 32'h0);
        expectLatency(1, 3, "w3_ld1");
        checkOutput("w3_ld1_dout", dout[1], 32'h0BADF00D);
        holdCycle();
        expectLatency(1, 3, "w3_ld2");
        checkOutput("w3_ld2_dout", dout[1], 32'h0BADF00D);
        applyStimulus(1, 1'b0, 1'b0, 32'h40, SZ_WORD, 1'b0, 32'h0);

        // Two wait states: a dropped store must neither pulse ready nor write
        applyStimulus(2, 1'b0, 1'b1, 32'h80, SZ_WORD, 1'b0, 32'h13572468);
        expectLatency(2, 2, "w2_st");
        applyStimulus(2, 1'b0, 1'b1, 32'h80, SZ_WORD, 1'b0, 32'hFFFF0000);
        checkOutput("abort_c1", 32'(rdy[2]), 32'd0);
        holdCycle();
        checkOutput("abort_c2", 32'(rdy[2]), 32'd0);
        applyStimulus(2, 1'b0, 1'b0, 32'h80, SZ_WORD, 1'b0, 32'hFFFF0000);
        checkOutput("abort_drop", 32'(rdy[2]), 32'd0);
        holdCycle();
        checkOutput("abort_idle", 32'(rdy[2]), 32'd0);
        applyStimulus(2, 1'b1, 1'b0, 32'h80, SZ_WORD, 1'b0, 32'h0);
        expectLatency(2, 2, "w2_ld");
        checkOutput("abort_unchanged", dout[2], 32'h13572468);
        applyStimulus(2, 1'b0, 1'b0, 32'h80, SZ_WORD, 1'b0, 32'h0);

        // Reset in the middle of a three-wait-state store
        applyStimulus(1, 1'b0, 1'b1, 32'h40, SZ_WORD, 1'b0, 32'h77777777);
        holdCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready_w3", 32'(rdy[1]), 32'd0);
        checkOutput("midrst_ready_w0", 32'(rdy[0]), 32'd1);
        checkOutput("midrst_err_w0",   32'(er[0]),  32'd0);
        holdCycle();
        applyStimulus(1, 1'b0, 1'b0, 32'h40, SZ_WORD, 1'b0, 32'h0);
        rst_n = 1'b1;
`ifdef DMEM_RESET_CLEAR_EN
        afterReset = 32'h0;
`else
        afterReset = 32'h0BADF00D;
`endif
        applyStimulus(1, 1'b1, 1'b0, 32'h40, SZ_WORD, 1'b0, 32'h0);
        expectLatency(1, 3, "postrst_ld");
        checkOutput("postrst_dout", dout[1], afterReset);
        applyStimulus(1, 1'b0, 1'b0, 32'h40, SZ_WORD, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_ws.md
# data_memory_ws

Parametrised data memory for the ARM pipeline's MEM stage, with byte/halfword/word accesses, signed loads, alignment and range checking, and a configurable number of wait states. A `ready` output lets the hazard/freeze logic stall the pipeline while an access is in flight. The block replaces the single-cycle word-only data memory: with `WAIT_CYCLES=0` and word accesses it behaves the same.

## Interface
Parameters:
- `DATA_W`, 32: word width. Fixed at 32 for the ARM core; still parametrised for the bench.
- `DEPTH`, 64: number of words. Must be a power of two, at least 4.
- `WAIT_CYCLES`, 0: extra cycles per access, range 0..15.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `mem_r_en`, input, 1: load request.
- `mem_w_en`, input, 1: store request.
- `address`, input, 32: byte address.
- `size`, input, 2: access size. 00 is byte, 01 is halfword, 10 is word, 11 is treated as word.
- `signed_ld`, input, 1: sign-extend byte/halfword loads.
- `dataIn`, input, 32: store data, right-justified.
- `dataOut`, output, 32: load data, valid only while `ready`=1 for a load.
- `ready`, output, 1: access completes in this cycle.
- `err`, output, 1: current access is misaligned or out of range. Valid while `ready`=1.

## Operation
- Addressing:
  - Word index is `address[$clog2(DEPTH)+1:2]`.
  - Byte lane is `address[1:0]`, little-endian.
- Request:
  - A request is present when `mem_r_en | mem_w_en`.
  - If both are high, the access is a store. `dataOut` returns the pre-store word.
- Stores write only the addressed lanes:
  - Byte: writes `dataIn[7:0]` to lane `address[1:0]`.
  - Halfword: writes `dataIn[15:0]` to lanes `{address[1],0}` and `{address[1],1}`.
  - Word: writes all four lanes.
- Loads extract the addressed byte or halfword and right-justify it. They zero-extend, or sign-extend when `signed_ld`=1. Word loads return the full word.
- Errors. Any of the following is an error:
  - Halfword access with `address[0]`=1.
  - Word access with `address[1:0]`≠0.
  - `address` ≥ `4*DEPTH`.
  
  On an error access, `err`=1 and `dataOut`=0 on the completion cycle, and there is no write.
- When no load is completing, `dataOut`=0.
- FSM states: `IDLE`, `WAIT`.
  - `IDLE` with a request and `WAIT_CYCLES>0`: load `cnt`=`WAIT_CYCLES-1`, go to `WAIT`, `ready`=0.
  - `WAIT` with `cnt`≠0: decrement `cnt`, `ready`=0.
  - `WAIT` with `cnt`=0: `ready`=1, the access completes, go to `IDLE`.
  - With `WAIT_CYCLES=0` the FSM stays in `IDLE`. `ready`=1 combinationally and every access completes in its own cycle.
- Abort: if the request drops while in `WAIT`, return to `IDLE`. No write occurs and `ready` is not asserted.
- While `ready`=0 the requester must hold `address`, `size`, `signed_ld`, `dataIn`, `mem_r_en` and `mem_w_en` stable. Behaviour on a change other than a drop is undefined.
- Reset (asynchronous, while `rst`=0):
  - `state`=`IDLE`, `cnt`=0, `err`=0, `dataOut`=0.
  - `ready`=1 if `WAIT_CYCLES=0`, else 0.
  - Array contents are governed by the macro below.
  - Reset mid-access aborts the access with no write.

## Timing
- Access latency is `WAIT_CYCLES+1` cycles, counted from the cycle the request first appears to the cycle with `ready`=1, inclusive.
- Stores commit on the rising edge that closes the `ready`=1 cycle.
- Loads read combinationally from the array during the `ready`=1 cycle.
- Back-to-back accesses:
  - With `WAIT_CYCLES=0`, one per cycle.
  - Otherwise, a new request in the cycle after `ready` starts a fresh count with no idle gap.
- A store followed by a load to the same word returns the new data.
- `ready`, `err` and `dataOut` are combinational from state and inputs. No output depends on a register loaded in the same cycle as the request.

## Configuration
- `DMEM_RESET_CLEAR_EN` defined: asserting `rst` asynchronously clears all `DEPTH` words to 0. This matches the previous memory's reset-to-zero contents.
- Not defined: the array has no reset and contents survive `rst`. Only the FSM, counter and outputs reset. This allows RAM inference.

## Structure
- Package `dmem_pkg`:
  - Size encodings `SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10.
  - FSM state typedef (`IDLE`, `WAIT`).
  - Counter width constant (4 bits).
- Sub-module `dmem_lane_align` (combinational):
  - From `size`, `address[1:0]` and `dataIn`, produces a 4-bit byte-enable and the lane-shifted store word.
  - From the read word, `size`, `address[1:0]` and `signed_ld`, produces the extended load value.
  - Also produces the misalign flag.
- Top level: array, range check, FSM and counter.

## Test plan
- `WAIT_CYCLES=0`: store word 0xDEADBEEF at 0x10, then load 0x10 → `ready`=1 every cycle, `dataOut`=0xDEADBEEF the next cycle.
- Byte store 0x80 at 0x13 over word 0, then `signed_ld` byte load 0x13 → 0xFFFFFF80. Unsigned load gives 0x00000080. Word load at 0x10 gives 0x80000000.
- `WAIT_CYCLES=3`, load held → `ready` low 3 cycles, high on the 4th with data. A back-to-back second load completes 4 cycles later.
- Halfword store at 0x21, or word load at 0x102 with `DEPTH`=64 → `err`=1, `dataOut`=0, memory unchanged when read back.
- `WAIT_CYCLES=2`: drop `mem_w_en` after 1 cycle → no `ready` pulse, target word unchanged.
- Reset asserted mid-`WAIT` → immediate `IDLE`, `ready`=0, no write. With `DMEM_RESET_CLEAR_EN`, a later load returns 0. Without it, prior contents are retained.
